// File: rtl/complex_mul_pipe.sv
// Pipelined signed fixed-point complex multiplier with conj mode,
// rounding, output saturation and a single global stall enable.
module complex_mul_pipe #(
   parameter int p_inputWidth    = 8,
   parameter int p_PointPosition = 3,
   parameter int p_OutWidth      = 8,
   parameter bit p_Round         = 1'b1
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_n,
   input  logic                    i_Valid,
   output logic                    o_Ready,
   input  logic [p_inputWidth-1:0] i_Ar,
   input  logic [p_inputWidth-1:0] i_Ai,
   input  logic [p_inputWidth-1:0] i_Br,
   input  logic [p_inputWidth-1:0] i_Bi,
   input  logic                    i_Conj,
   output logic                    o_Valid,
   input  logic                    i_Ready,
   output logic [p_OutWidth-1:0]   o_ResR,
   output logic [p_OutWidth-1:0]   o_ResI,
   output logic                    o_Sat,
   output logic                    o_SatSticky,
   input  logic                    i_ClrSat
);

   localparam int W  = p_inputWidth;
   localparam int PW = 2 * W;
   localparam int SW = 2 * W + 1;
   localparam int OW = p_OutWidth;
   localparam int P  = p_PointPosition;
   localparam int RndSh = (P > 0) ? P - 1 : 0;
   localparam logic signed [SW-1:0] RndK =
      (p_Round && P > 0) ? (SW'(1) << RndSh) : '0;
   localparam logic [OW-1:0] MaxV = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] MinV = {1'b1, {(OW-1){1'b0}}};

   logic en;
   assign en      = ~o_Valid | i_Ready;
   assign o_Ready = en;

   logic                v0, c0;
   logic signed [W-1:0] ar0, ai0, br0, bi0;

   logic                 v1, c1;
   logic signed [PW-1:0] pArBr, pAiBi, pArBi, pAiBr;

   logic                 v2;
   logic signed [SW-1:0] sumR, sumI;

   logic signed [SW-1:0] shR, shI;
   logic [OW:0]          fitR, fitI;

   // Input operand register ahead of the multipliers.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         v0  <= 1'b0;
         c0  <= 1'b0;
         ar0 <= '0;
         ai0 <= '0;
         br0 <= '0;
         bi0 <= '0;
      end else if (en) begin
         v0  <= i_Valid;
         c0  <= i_Conj;
         ar0 <= $signed(i_Ar);
         ai0 <= $signed(i_Ai);
         br0 <= $signed(i_Br);
         bi0 <= $signed(i_Bi);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         v1    <= 1'b0;
         c1    <= 1'b0;
         pArBr <= '0;
         pAiBi <= '0;
         pArBi <= '0;
         pAiBr <= '0;
      end else if (en) begin
         v1    <= v0;
         c1    <= c0;
         pArBr <= PW'(ar0) * PW'(br0);
         pAiBi <= PW'(ai0) * PW'(bi0);
         pArBi <= PW'(ar0) * PW'(bi0);
         pAiBr <= PW'(ai0) * PW'(br0);
      end
   end

   // Conjugation flips add/sub per product; Bi itself is never negated.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         v2   <= 1'b0;
         sumR <= '0;
         sumI <= '0;
      end else if (en) begin
         v2 <= v1;
         if (c1) begin
            sumR <= SW'(pArBr) + SW'(pAiBi) + RndK;
            sumI <= SW'(pAiBr) - SW'(pArBi) + RndK;
         end else begin
            sumR <= SW'(pArBr) - SW'(pAiBi) + RndK;
            sumI <= SW'(pArBi) + SW'(pAiBr) + RndK;
         end
      end
   end

   function automatic logic [OW:0] clip(input logic signed [SW-1:0] s);
      logic [SW-OW:0] top;
      top = s[SW-1:OW-1];
      if ((&top) || (~|top)) begin
         return {1'b0, s[OW-1:0]};
      end else if (s[SW-1]) begin
         return {1'b1, MinV};
      end else begin
         return {1'b1, MaxV};
      end
   endfunction

   always_comb begin
      shR  = sumR >>> P;
      shI  = sumI >>> P;
      fitR = clip(shR);
      fitI = clip(shI);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         o_Valid <= 1'b0;
         o_ResR  <= '0;
         o_ResI  <= '0;
         o_Sat   <= 1'b0;
      end else if (en) begin
         o_Valid <= v2;
         o_ResR  <= fitR[OW-1:0];
         o_ResI  <= fitI[OW-1:0];
         o_Sat   <= v2 & (fitR[OW] | fitI[OW]);
      end
   end

   // A saturating handshake beats a simultaneous clear.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         o_SatSticky <= 1'b0;
      end else if (o_Valid & i_Ready & o_Sat) begin
         o_SatSticky <= 1'b1;
      end else if (i_ClrSat) begin
         o_SatSticky <= 1'b0;
      end
   end

endmodule
